am_move_sequencer: RTL and testbench

Controller that sequences one `all_moves` generation pass and drains the result as a valid/ready move stream.
- Accepts a start request and pulses `board_valid` into `all_moves`, then waits for `am_moves_ready`.
- Walks `am_move_index` from 0 to `am_move_count-1`, honouring the move RAM read latency, and presents each UCI move downstream.
- Clears `all_moves` and reports a completion status.
- Sits between the search control logic and the `all_moves` move generator, replacing ad-hoc per-user sequencing.

---
 rtl/am_move_sequencer.sv | 173 +++++++++++++++++
 tb/tb_am_move_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/am_move_sequencer.sv
`default_nettype none
// ============================================================================
// am_move_sequencer : runs one all_moves pass and drains moves as a stream.
// Optional watchdog in WAIT_READY enabled by AMSEQ_TIMEOUT_EN.  Rev 1.0
// ============================================================================
module am_move_sequencer #(
    parameter int MAX_POSITIONS_LOG2 = 8,
    parameter int UCI_WIDTH          = 16,
    parameter int READ_LATENCY       = 2,
    parameter int TIMEOUT_CYCLES     = 4096
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start_in,
    output logic                          busy_out,
    output logic                          board_valid_out,
    input  logic                          am_idle_in,
    input  logic                          am_moves_ready_in,
    input  logic [MAX_POSITIONS_LOG2-1:0] am_move_count_in,
    input  logic                          initial_mate_in,
    input  logic                          initial_stalemate_in,
    input  logic [UCI_WIDTH-1:0]          uci_in,
    output logic [MAX_POSITIONS_LOG2-1:0] am_move_index_out,
    output logic                          am_clear_moves_out,
    output logic                          mv_valid_out,
    input  logic                          mv_ready_in,
    output logic [UCI_WIDTH-1:0]          mv_uci_out,
    output logic [MAX_POSITIONS_LOG2-1:0] mv_index_out,
    output logic                          mv_last_out,
    output logic                          done_out,
    output logic [1:0]                    status_out
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_LAUNCH     = 3'd1;
    localparam logic [2:0] S_WAIT_READY = 3'd2;
    localparam logic [2:0] S_FETCH      = 3'd3;
    localparam logic [2:0] S_PRESENT    = 3'd4;
    localparam logic [2:0] S_CLEAR      = 3'd5;
    localparam logic [2:0] S_CLEAR_WAIT = 3'd6;
    localparam logic [2:0] S_DONE       = 3'd7;

    localparam logic [2:0] c_LAT_LAST = 3'(READ_LATENCY - 1);

    logic [2:0]                    r_state;
    logic [2:0]                    w_next;
    logic [2:0]                    r_lat;
    logic [MAX_POSITIONS_LOG2-1:0] r_idx;
    logic [MAX_POSITIONS_LOG2-1:0] r_count_q;
    logic [UCI_WIDTH-1:0]          r_uci;
    logic [1:0]                    r_status;
    logic [1:0]                    r_status_pend;
    logic                          w_last;
    logic                          w_timeout;
    logic                          w_unused;

`ifdef AMSEQ_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_TO_W-1:0] r_to_cnt;
    logic [c_TO_W-1:0] w_to_inc;
    assign w_to_inc  = r_to_cnt + c_TO_W'(1);
    // Fires on the cycle the count would reach the limit, so CLEAR follows LAUNCH by TIMEOUT_CYCLES+1
    assign w_timeout = (w_to_inc == c_TO_W'(TIMEOUT_CYCLES));
    assign w_unused  = initial_stalemate_in;
`else
    assign w_timeout = 1'b0;
    assign w_unused  = initial_stalemate_in ^ TIMEOUT_CYCLES[0];
`endif

    assign w_last = (r_idx == (r_count_q - 1'b1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:       if (start_in && am_idle_in) w_next = S_LAUNCH;
            S_LAUNCH:     w_next = S_WAIT_READY;
            S_WAIT_READY: begin
                if (am_moves_ready_in) begin
                    w_next = (am_move_count_in == '0) ? S_CLEAR : S_FETCH;
                end else if (w_timeout) begin
                    w_next = S_CLEAR;
                end
            end
            S_FETCH:      if (r_lat == 3'd0) w_next = S_PRESENT;
            S_PRESENT:    if (mv_ready_in) w_next = w_last ? S_CLEAR : S_FETCH;
            S_CLEAR:      w_next = S_CLEAR_WAIT;
            S_CLEAR_WAIT: w_next = S_DONE;
            S_DONE:       w_next = S_IDLE;
            default:      w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy_out           = (r_state != S_IDLE);
        board_valid_out    = (r_state == S_LAUNCH);
        am_clear_moves_out = (r_state == S_CLEAR);
        mv_valid_out       = (r_state == S_PRESENT);
        mv_last_out        = (r_state == S_PRESENT) && w_last;
        done_out           = (r_state == S_DONE);
    end

    // Datapath; status is staged and published on entry to DONE so it changes with done_out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lat         <= 3'd0;
            r_idx         <= '0;
            r_count_q     <= '0;
            r_uci         <= '0;
            r_status      <= 2'd0;
            r_status_pend <= 2'd0;
`ifdef AMSEQ_TIMEOUT_EN
            r_to_cnt      <= '0;
`endif
        end else begin
            case (r_state)
                S_LAUNCH: begin
                    r_idx <= '0;
`ifdef AMSEQ_TIMEOUT_EN
                    r_to_cnt <= '0;
`endif
                end
                S_WAIT_READY: begin
`ifdef AMSEQ_TIMEOUT_EN
                    r_to_cnt <= w_to_inc;
`endif
                    if (am_moves_ready_in) begin
                        r_count_q <= am_move_count_in;
                        r_lat     <= c_LAT_LAST;
                        if (am_move_count_in == '0) begin
                            r_status_pend <= initial_mate_in ? 2'd1 : 2'd2;
                        end
                    end else if (w_timeout) begin
                        r_status_pend <= 2'd3;
                    end
                end
                S_FETCH: begin
                    if (r_lat == 3'd0) begin
                        r_uci <= uci_in;
                    end else begin
                        r_lat <= r_lat - 3'd1;
                    end
                end
                S_PRESENT: begin
                    if (mv_ready_in) begin
                        if (w_last) begin
                            r_status_pend <= 2'd0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                            r_lat <= c_LAT_LAST;
                        end
                    end
                end
                S_CLEAR_WAIT: r_status <= r_status_pend;
                default: ;
            endcase
        end
    end

    assign am_move_index_out = r_idx;
    assign mv_index_out      = r_idx;
    assign mv_uci_out        = r_uci;
    assign status_out        = r_status;

endmodule
`default_nettype wire

// File: tb/tb_am_move_sequencer.sv
`default_nettype none
// ============================================================================
// tb_am_move_sequencer : directed bench for am_move_sequencer (RL=2).
// Rev 1.0
// ============================================================================
module tb_am_move_sequencer;

    localparam int c_RL = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_in;
    logic        busy_out;
    logic        board_valid_out;
    logic        am_idle_in;
    logic        am_moves_ready_in;
    logic [7:0]  am_move_count_in;
    logic        initial_mate_in;
    logic        initial_stalemate_in;
    logic [15:0] uci_in;
    logic [7:0]  am_move_index_out;
    logic        am_clear_moves_out;
    logic        mv_valid_out;
    logic        mv_ready_in;
    logic [15:0] mv_uci_out;
    logic [7:0]  mv_index_out;
    logic        mv_last_out;
    logic        done_out;
    logic [1:0]  status_out;

    int n_vec = 0;
    int n_err = 0;

    am_move_sequencer #(
        .MAX_POSITIONS_LOG2(8),
        .UCI_WIDTH(16),
        .READ_LATENCY(c_RL),
        .TIMEOUT_CYCLES(100)
    ) u_dut (
        .clk(clk),
        .reset(reset),
        .start_in(start_in),
        .busy_out(busy_out),
        .board_valid_out(board_valid_out),
        .am_idle_in(am_idle_in),
        .am_moves_ready_in(am_moves_ready_in),
        .am_move_count_in(am_move_count_in),
        .initial_mate_in(initial_mate_in),
        .initial_stalemate_in(initial_stalemate_in),
        .uci_in(uci_in),
        .am_move_index_out(am_move_index_out),
        .am_clear_moves_out(am_clear_moves_out),
        .mv_valid_out(mv_valid_out),
        .mv_ready_in(mv_ready_in),
        .mv_uci_out(mv_uci_out),
        .mv_index_out(mv_index_out),
        .mv_last_out(mv_last_out),
        .done_out(done_out),
        .status_out(status_out)
    );

    always #5 clk = ~clk;

    // Move RAM model: data for an index is usable two edges after the index changes
    logic [7:0] r_idx_d1 = 8'd0;
    always @(posedge clk) r_idx_d1 <= am_move_index_out;
    assign uci_in = 16'(r_idx_d1 * 3);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Clear/done tail, entered at the cycle after the final edge
    task automatic tail(input logic [1:0] exp_status);
        chk("clear_pulse", am_clear_moves_out, 1);
        chk("no_done_early", done_out, 0);
        @(negedge clk);
        chk("clear_one_cycle", am_clear_moves_out, 0);
        chk("busy_clear_wait", busy_out, 1);
        @(negedge clk);
        chk("done_pulse", done_out, 1);
        chk("status_at_done", status_out, exp_status);
        @(negedge clk);
        chk("done_one_cycle", done_out, 0);
        chk("busy_low", busy_out, 0);
        chk("status_held", status_out, exp_status);
    endtask

    task automatic launch(input int cnt, input bit mate, input bit stale);
        @(negedge clk);
        start_in = 1'b1;
        am_idle_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        chk("board_valid", board_valid_out, 1);
        chk("busy_launch", busy_out, 1);
        @(negedge clk);
        chk("board_valid_pulse", board_valid_out, 0);
        initial_mate_in = mate;
        initial_stalemate_in = stale;
        am_move_count_in = 8'(cnt);
        am_moves_ready_in = 1'b1;
        @(negedge clk);
        am_moves_ready_in = 1'b0;
        am_move_count_in = 8'hFF;
    endtask

    task automatic run_pass(input int cnt, input bit mate, input bit stale,
                            input int stall_at, input int stall_len, input logic [1:0] exp_status);
        int beat = 0;
        int cyc = 1;
        int cyc_last = 0;
        int stalls = 0;
        launch(cnt, mate, stale);
        if (cnt == 0) begin
            chk("no_valid_zero", mv_valid_out, 0);
        end else begin
            mv_ready_in = 1'b1;
            while (beat < cnt && cyc < 2000) begin
                if (mv_valid_out) begin
                    if (beat == 0) chk("first_latency", cyc, c_RL + 1);
                    chk("index", am_move_index_out, beat);
                    chk("mv_index", mv_index_out, beat);
                    chk("uci", mv_uci_out, 16'(beat * 3));
                    chk("last", mv_last_out, (beat == cnt - 1) ? 1 : 0);
                    if (beat == stall_at && stalls < stall_len) begin
                        mv_ready_in = 1'b0;
                        stalls++;
                    end else begin
                        mv_ready_in = 1'b1;
                        beat++;
                        if (beat == cnt) cyc_last = cyc;
                    end
                end
                @(negedge clk);
                cyc++;
            end
            chk("beats_done", beat, cnt);
            chk("pass_len", cyc_last, cnt * (c_RL + 1) + stall_len);
            mv_ready_in = 1'b1;
        end
        tail(exp_status);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        start_in = 1'b0;
        am_idle_in = 1'b1;
        am_moves_ready_in = 1'b0;
        am_move_count_in = 8'd0;
        initial_mate_in = 1'b0;
        initial_stalemate_in = 1'b0;
        mv_ready_in = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy_out, 0);
        chk("rst_board_valid", board_valid_out, 0);
        chk("rst_mv_valid", mv_valid_out, 0);
        chk("rst_done", done_out, 0);
        chk("rst_status", status_out, 0);
        chk("rst_uci", mv_uci_out, 0);
        chk("rst_index", am_move_index_out, 0);
        reset = 1'b0;

        // Start while all_moves is busy must be dropped, not queued
        am_idle_in = 1'b0;
        start_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_lo_bv", board_valid_out, 0);
            chk("idle_lo_busy", busy_out, 0);
        end
        start_in = 1'b0;
        am_idle_in = 1'b1;
        @(negedge clk);
        chk("start_not_queued", busy_out, 0);

        run_pass(20, 1'b0, 1'b0, -1, 0, 2'd0);
        run_pass(0, 1'b1, 1'b0, -1, 0, 2'd1);
        run_pass(0, 1'b0, 1'b1, -1, 0, 2'd2);

        // Reset while presenting index 1 aborts everything at once
        launch(4, 1'b0, 1'b0);
        mv_ready_in = 1'b1;
        for (int i = 0; i < 20 && !(mv_valid_out && am_move_index_out == 8'd1); i++) begin
            @(negedge clk);
        end
        mv_ready_in = 1'b0;
        chk("pre_rst_uci", mv_uci_out, 16'd3);
        chk("pre_rst_status", status_out, 2'd2);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy_out, 0);
        chk("mid_rst_valid", mv_valid_out, 0);
        chk("mid_rst_uci", mv_uci_out, 0);
        chk("mid_rst_index", mv_index_out, 0);
        chk("mid_rst_status", status_out, 0);
        chk("mid_rst_clear", am_clear_moves_out, 0);
        @(negedge clk);
        reset = 1'b0;
        mv_ready_in = 1'b1;

        run_pass(5, 1'b0, 1'b0, 2, 10, 2'd0);
        run_pass(1, 1'b0, 1'b0, -1, 0, 2'd0);

`ifdef AMSEQ_TIMEOUT_EN
        begin
            int n = 0;
            @(negedge clk);
            start_in = 1'b1;
            @(negedge clk);
            start_in = 1'b0;
            chk("to_board_valid", board_valid_out, 1);
            while (!am_clear_moves_out && n < 400) begin
                @(negedge clk);
                n++;
            end
            chk("to_clear_cycle", n, 101);
            tail(2'd3);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
